// File: rtl/wb_skid_stage.sv
// MEM->WB pipeline stage with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and squashing of writes aimed at the discard register.
module wb_skid_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LANES    = 1,
  parameter int unsigned NOP_ADDR = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [LANES*DATA_W-1:0]   mem_wdata,
  input  logic [LANES*ADDR_W-1:0]   mem_wd,
  input  logic [LANES-1:0]          mem_wreg,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [LANES*DATA_W-1:0]   wb_wdata,
  output logic [LANES*ADDR_W-1:0]   wb_wd,
  output logic [LANES-1:0]          wb_wreg,
  output logic [1:0]                occupancy
);

  localparam int unsigned DW = LANES * DATA_W;
  localparam int unsigned AW = LANES * ADDR_W;
  localparam logic [ADDR_W-1:0] NOP     = ADDR_W'(NOP_ADDR);
  localparam logic [AW-1:0]     NOP_ALL = {LANES{NOP}};

  logic            m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d, s_wdata_q, s_wdata_d;
  logic [AW-1:0]   m_wd_q,    m_wd_d,    s_wd_q,    s_wd_d;
  logic [LANES-1:0] m_wreg_q, m_wreg_d,  s_wreg_q,  s_wreg_d;
  logic            mem_ready_q, mem_ready_d;
  logic [1:0]      occupancy_q, occupancy_d;
  logic [LANES-1:0] in_wreg;
  logic            acc, drn;

  // Per-lane squash of writes targeting the discard register
  always_comb begin
    in_wreg = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      in_wreg[i] = mem_wreg[i] & (mem_wd[i*ADDR_W +: ADDR_W] != NOP);
    end
  end

  assign acc = mem_valid & mem_ready_q;
  assign drn = m_valid_q & wb_ready;

  // Entry update in priority order; M.wreg is kept clear whenever M is empty
  // so the qualified write enables come straight from a flop.
  always_comb begin
    m_valid_d = m_valid_q;
    m_wdata_d = m_wdata_q;
    m_wd_d    = m_wd_q;
    m_wreg_d  = m_wreg_q;
    s_valid_d = s_valid_q;
    s_wdata_d = s_wdata_q;
    s_wd_d    = s_wd_q;
    s_wreg_d  = s_wreg_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (s_valid_q && drn) begin
      m_valid_d = 1'b1;
      m_wdata_d = s_wdata_q;
      m_wd_d    = s_wd_q;
      m_wreg_d  = s_wreg_q;
      s_valid_d = 1'b0;
    end else if (acc && (!m_valid_q || drn)) begin
      m_valid_d = 1'b1;
      m_wdata_d = mem_wdata;
      m_wd_d    = mem_wd;
      m_wreg_d  = in_wreg;
    end else if (acc) begin
      s_valid_d = 1'b1;
      s_wdata_d = mem_wdata;
      s_wd_d    = mem_wd;
      s_wreg_d  = in_wreg;
    end else if (drn) begin
      m_valid_d = 1'b0;
    end
    if (!m_valid_d) begin
      m_wreg_d = '0;
    end
    mem_ready_d = !s_valid_d;
    occupancy_d = 2'(m_valid_d) + 2'(s_valid_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q   <= 1'b0;
      m_wdata_q   <= '0;
      m_wd_q      <= NOP_ALL;
      m_wreg_q    <= '0;
      s_valid_q   <= 1'b0;
      s_wdata_q   <= '0;
      s_wd_q      <= NOP_ALL;
      s_wreg_q    <= '0;
      mem_ready_q <= 1'b1;
      occupancy_q <= 2'd0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_wdata_q   <= m_wdata_d;
      m_wd_q      <= m_wd_d;
      m_wreg_q    <= m_wreg_d;
      s_valid_q   <= s_valid_d;
      s_wdata_q   <= s_wdata_d;
      s_wd_q      <= s_wd_d;
      s_wreg_q    <= s_wreg_d;
      mem_ready_q <= mem_ready_d;
      occupancy_q <= occupancy_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign wb_valid  = m_valid_q;
  assign wb_wdata  = m_wdata_q;
  assign wb_wd     = m_wd_q;
  assign wb_wreg   = m_wreg_q;
  assign occupancy = occupancy_q;

endmodule

// File: tb/tb_wb_skid_stage.sv
// Self-checking bench for wb_skid_stage (LANES=2): directed vector table,
// reset-mid-transfer sequence, then random traffic against a queue model.
module tb_wb_skid_stage;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned LANES  = 2;

  logic clk = 1'b0;
  logic rst, flush, mem_valid, mem_ready, wb_valid, wb_ready;
  logic [LANES*DATA_W-1:0] mem_wdata, wb_wdata;
  logic [LANES*ADDR_W-1:0] mem_wd, wb_wd;
  logic [LANES-1:0] mem_wreg, wb_wreg;
  logic [1:0] occupancy;

  int tests = 0;
  int fails = 0;

  wb_skid_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .NOP_ADDR(0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_wdata(wb_wdata), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        mv;
    logic [63:0] wdata;
    logic [9:0]  wd;
    logic [1:0]  wreg;
    logic        rdy;
    logic        e_valid;
    logic [1:0]  e_wreg;
    logic [1:0]  e_occ;
    logic        e_ready;
    logic [63:0] e_wdata;
    logic [9:0]  e_wd;
  } vec_t;

  typedef struct {
    logic [63:0] wdata;
    logic [9:0]  wd;
    logic [1:0]  wreg;
  } bundle_t;

  vec_t    vecs[13];
  bundle_t q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] squash(input logic [9:0] wd, input logic [1:0] wreg);
    logic [1:0] r;
    for (int i = 0; i < 2; i++) r[i] = wreg[i] && (wd[i*5 +: 5] != 5'd0);
    return r;
  endfunction

  task automatic drive(input logic f, input logic mv, input logic [63:0] wdata,
                       input logic [9:0] wd, input logic [1:0] wreg, input logic rdy);
    flush = f; mem_valid = mv; mem_wdata = wdata; mem_wd = wd; mem_wreg = wreg; wb_ready = rdy;
  endtask

  function automatic vec_t mk(input logic f, input logic mv, input logic [63:0] wdata,
                              input logic [9:0] wd, input logic [1:0] wreg, input logic rdy,
                              input logic ev, input logic [1:0] ewreg, input logic [1:0] eocc,
                              input logic erdy, input logic [63:0] ewdata, input logic [9:0] ewd);
    vec_t v;
    v.flush = f; v.mv = mv; v.wdata = wdata; v.wd = wd; v.wreg = wreg; v.rdy = rdy;
    v.e_valid = ev; v.e_wreg = ewreg; v.e_occ = eocc; v.e_ready = erdy;
    v.e_wdata = ewdata; v.e_wd = ewd;
    return v;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 64'(wb_valid), 64'd0);
    chk({tag, "_wreg"},  64'(wb_wreg), 64'd0);
    chk({tag, "_wd"},    64'(wb_wd), 64'd0);
    chk({tag, "_wdata"}, wb_wdata, 64'd0);
    chk({tag, "_ready"}, 64'(mem_ready), 64'd1);
    chk({tag, "_occ"},   64'(occupancy), 64'd0);
  endtask

  initial begin
    bundle_t b, nb;
    logic mr;
    vecs[0]  = mk(0,0,64'h0,10'h0,2'b00,1, 0,2'b00,2'd0,1, 64'h0,10'h0);
    vecs[1]  = mk(0,1,64'h00000000_DEADBEEF,10'h003,2'b01,1, 1,2'b01,2'd1,1, 64'h00000000_DEADBEEF,10'h003);
    vecs[2]  = mk(0,0,64'h0,10'h0,2'b00,1, 0,2'b00,2'd0,1, 64'h0,10'h0);
    vecs[3]  = mk(0,1,64'h0000000A_0000000A,10'h001,2'b01,1, 1,2'b01,2'd1,1, 64'h0000000A_0000000A,10'h001);
    vecs[4]  = mk(0,1,64'h0000000B_0000000B,10'h002,2'b01,0, 1,2'b01,2'd2,0, 64'h0000000A_0000000A,10'h001);
    vecs[5]  = mk(0,1,64'h0000000C_0000000C,10'h003,2'b01,0, 1,2'b01,2'd2,0, 64'h0000000A_0000000A,10'h001);
    vecs[6]  = mk(0,1,64'h0000000C_0000000C,10'h003,2'b01,1, 1,2'b01,2'd1,1, 64'h0000000B_0000000B,10'h002);
    vecs[7]  = mk(0,1,64'h0000000C_0000000C,10'h003,2'b01,1, 1,2'b01,2'd1,1, 64'h0000000C_0000000C,10'h003);
    vecs[8]  = mk(0,0,64'h0,10'h0,2'b00,1, 0,2'b00,2'd0,1, 64'h0,10'h0);
    vecs[9]  = mk(0,1,64'h00005678_00001234,10'h0E0,2'b11,1, 1,2'b10,2'd1,1, 64'h00005678_00001234,10'h0E0);
    vecs[10] = mk(0,1,64'h0000000D_0000000D,10'h004,2'b01,0, 1,2'b10,2'd2,0, 64'h00005678_00001234,10'h0E0);
    vecs[11] = mk(1,1,64'h0000000E_0000000E,10'h005,2'b01,0, 0,2'b00,2'd0,1, 64'h0,10'h0);
    vecs[12] = mk(0,0,64'h0,10'h0,2'b00,1, 0,2'b00,2'd0,1, 64'h0,10'h0);

    rst = 1'b1;
    drive(0, 0, '0, '0, '0, 0);
    tick(); tick();
    chk_reset("reset");
    rst = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k].flush, vecs[k].mv, vecs[k].wdata, vecs[k].wd, vecs[k].wreg, vecs[k].rdy);
      tick();
      chk($sformatf("v%0d_valid", k), 64'(wb_valid), 64'(vecs[k].e_valid));
      chk($sformatf("v%0d_wreg", k), 64'(wb_wreg), 64'(vecs[k].e_wreg));
      chk($sformatf("v%0d_occ", k), 64'(occupancy), 64'(vecs[k].e_occ));
      chk($sformatf("v%0d_ready", k), 64'(mem_ready), 64'(vecs[k].e_ready));
      if (vecs[k].e_valid) begin
        chk($sformatf("v%0d_wdata", k), wb_wdata, vecs[k].e_wdata);
        chk($sformatf("v%0d_wd", k), 64'(wb_wd), 64'(vecs[k].e_wd));
      end
    end

    // Fill both entries, then reset while S is valid and wb_ready toggles
    drive(0, 1, 64'h11, 10'h021, 2'b11, 0); tick();
    drive(0, 1, 64'h22, 10'h042, 2'b11, 0); tick();
    chk("fill_occ", 64'(occupancy), 64'd2);
    drive(0, 1, 64'h33, 10'h063, 2'b11, 1); rst = 1'b1; tick();
    chk_reset("midrst");
    rst = 1'b0;
    drive(0, 0, '0, '0, '0, 0);

    // Random traffic against an in-order queue model of capacity 2
    q.delete();
    b = '{wdata: '0, wd: '0, wreg: '0};
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_valid", 64'(wb_valid), 64'(q.size() > 0));
      chk("rnd_occ", 64'(occupancy), 64'(q.size()));
      chk("rnd_ready", 64'(mem_ready), 64'(q.size() < 2));
      chk("rnd_wreg", 64'(wb_wreg), (q.size() > 0) ? 64'(q[0].wreg) : 64'd0);
      if (q.size() > 0) begin
        chk("rnd_wdata", wb_wdata, q[0].wdata);
        chk("rnd_wd", 64'(wb_wd), 64'(q[0].wd));
      end
      mr = (q.size() < 2);
      if (!(mem_valid && !mr)) begin
        mem_valid = ($urandom_range(0, 3) != 0);
        nb.wdata = {$urandom(), $urandom()};
        nb.wd = 10'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) == 0) nb.wd[4:0] = 5'd0;
        nb.wreg = 2'($urandom_range(0, 3));
        b = nb;
        mem_wdata = b.wdata; mem_wd = b.wd; mem_wreg = b.wreg;
      end
      wb_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 199) == 0);
      if (rst || flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && wb_ready) void'(q.pop_front());
        if (mem_valid && mr) q.push_back('{wdata: b.wdata, wd: b.wd, wreg: squash(b.wd, b.wreg)});
      end
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_skid_stage.md
Name: wb_skid_stage

Overview:
- Parametrised successor of the MEM→WB pipeline register, between memory-access stage and register-file write-back.
- Carries LANES parallel write-back channels, e.g. GPR plus HI/LO, or dual-issue.
- Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush and zero-register write squashing.
- Lets the write-back side stall without combinational ready paths back into MEM.

Parameters:
DATA_W, 32, width of one write-back data word
ADDR_W, 5, width of one destination register address
LANES, 1, number of parallel write-back channels (1..4)
NOP_ADDR, 0, register address whose writes are discarded; also the reset address value

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  synchronous pipeline flush; discards all buffered entries
mem_valid  in  1  MEM stage presents a bundle
mem_ready  out  1  stage can accept a bundle this cycle
mem_wdata  in  LANES*DATA_W  write data; lane i at bits [i*DATA_W +: DATA_W]
mem_wd  in  LANES*ADDR_W  destination addresses, packed the same way
mem_wreg  in  LANES  per-lane write enable
wb_valid  out  1  output bundle valid
wb_ready  in  1  write-back consumes the bundle
wb_wdata  out  LANES*DATA_W  write data to register file
wb_wd  out  LANES*ADDR_W  destination addresses
wb_wreg  out  LANES  per-lane write enable, qualified
occupancy  out  2  buffered entries, 0..2

Behaviour:
- Storage: main entry (M) and skid entry (S), each with a valid bit and wdata/wd/wreg fields.
- Outputs are driven only from M; no combinational path from mem_* to wb_*.
- mem_ready = !S.valid. It is a register-output function only, with no dependence on wb_ready.
- Accept: acc = mem_valid & mem_ready. Drain: drn = M.valid & wb_ready.
- Lane squash at capture: the stored wreg[i] = mem_wreg[i] & (mem_wd[i] != NOP_ADDR). wdata and wd are stored unchanged.
- Update rules, evaluated in priority order each clock:
  1. rst: M.valid=S.valid=0; all data fields 0; wd fields = NOP_ADDR; wreg fields 0.
  2. flush (rst low): M.valid=S.valid=0. Data fields may retain their values. An accept in the same cycle is discarded.
  3. S.valid & drn: M <= S; S.valid <= 0. acc is impossible because mem_ready=0.
  4. acc & (!M.valid | drn): M <= incoming bundle; M.valid=1.
  5. acc & M.valid & !drn: S <= incoming bundle; S.valid=1. M holds.
  6. drn only: M.valid <= 0.
  7. Otherwise all entries hold.
- Latency: 1 cycle from acc to wb_valid when empty. Sustained throughput is 1 bundle/cycle while wb_ready=1.
- Output qualification:
  - wb_wreg[i] = M.wreg[i] & M.valid, so it is never asserted when wb_valid=0.
  - When M.valid=0, wb_wdata and wb_wd show the last held values; consumers must gate with wb_wreg.
- occupancy = M.valid + S.valid.
- Reset values: wb_valid=0, wb_wdata=0, wb_wd=all lanes NOP_ADDR, wb_wreg=0, mem_ready=1, occupancy=0.
- Ordering: bundles leave in arrival order. No bundle is duplicated or dropped except by flush or rst.
- Full condition (occupancy=2): mem_ready=0. The bundle held on mem_* must stay stable until accepted.
- Simultaneous flush & drn: the drained bundle is considered consumed this cycle; the next cycle is empty.
- rst asserted mid-transfer: entries lost; identical to power-on reset state next cycle.

Test Plan:
- Reset then idle, LANES=2 → wb_valid=0, wb_wreg=2'b00, wb_wd={5'd0,5'd0}, mem_ready=1, occupancy=0.
- Single bundle wd=5'd3, wdata=32'hDEADBEEF, wreg=1, wb_ready=1 → next cycle wb_valid=1, wb_wd=3, wb_wdata=32'hDEADBEEF, wb_wreg=1; following cycle wb_valid=0.
- Back-to-back bundles A,B,C with wb_ready=0 from the cycle after A → occupancy 1 then 2, mem_ready=0 with C held. Release wb_ready → outputs A,B,C in order, one per cycle, with no loss.
- Lane squash: wd=0, wreg=1, wdata=32'h1234 → wb_valid=1, wb_wreg=0. In the same bundle, lane 1 wd=7, wreg=1 → wb_wreg=2'b10.
- Flush with occupancy=2 and mem_valid=1 → next cycle occupancy=0, wb_valid=0, mem_ready=1; the flushed-cycle input never appears.
- rst pulse while S.valid=1 and wb_ready toggling → all outputs at reset values the next cycle; random valid/ready scoreboard passes.
